// File: rtl/bcd_scan_counter.sv
// Prescaled multi-digit BCD up/down counter with modulus, load, carry and a registered 7-segment digit scanner.
// Optional build macro BCD_CNT_BLANK_EN: blank leading zero digits (digit 0 always shown).
module bcd_scan_counter #(
  parameter int DIV      = 50,
  parameter int DIGITS   = 2,
  parameter int MODULUS  = 60,
  parameter int SCAN_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value,
  output logic                  tick,
  output logic                  carry,
  output logic [2:0]            sel,
  output logic [7:0]            seg
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  function automatic logic [W-1:0] to_bcd(input int v);
    int r;
    r = v;
    to_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  // Top of the count range in BCD; with valid digits a BCD compare equals a numeric compare.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'b00111111;
      4'd1:    seg_decode = 8'b00000110;
      4'd2:    seg_decode = 8'b01011011;
      4'd3:    seg_decode = 8'b01001111;
      4'd4:    seg_decode = 8'b01100110;
      4'd5:    seg_decode = 8'b01101101;
      4'd6:    seg_decode = 8'b01111101;
      4'd7:    seg_decode = 8'b00000111;
      4'd8:    seg_decode = 8'b01111111;
      4'd9:    seg_decode = 8'b01101111;
      default: seg_decode = 8'b01111001;
    endcase
  endfunction

  logic [PW-1:0] psc;
  logic          tick_cond;

  assign tick_cond = (psc == PW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) psc <= '0;
    else if (tick_cond) psc <= '0;
    else psc <= psc + PW'(1);
  end

  logic [W-1:0] val_inc;
  logic [W-1:0] val_dec;
  logic         inc_c;
  logic         dec_b;
  logic         load_ok;

  always_comb begin
    val_inc = value;
    val_dec = value;
    inc_c   = 1'b1;
    dec_b   = 1'b1;
    load_ok = (load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_c) begin
        if (value[4*i +: 4] == 4'd9) val_inc[4*i +: 4] = 4'd0;
        else begin
          val_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
          inc_c = 1'b0;
        end
      end
      if (dec_b) begin
        if (value[4*i +: 4] == 4'd0) val_dec[4*i +: 4] = 4'd9;
        else begin
          val_dec[4*i +: 4] = value[4*i +: 4] - 4'd1;
          dec_b = 1'b0;
        end
      end
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // An invalid load still takes priority: the value holds and the tick step is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      tick  <= tick_cond;
      carry <= 1'b0;
      if (load) begin
        if (load_ok) value <= load_val;
      end else if (tick_cond && en) begin
        if (up) begin
          if (value == MAX_BCD) begin
            value <= '0;
            carry <= 1'b1;
          end else value <= val_inc;
        end else begin
          if (value == '0) begin
            value <= MAX_BCD;
            carry <= 1'b1;
          end else value <= val_dec;
        end
      end
    end
  end

  logic [SW-1:0] scan_cnt;
  logic [2:0]    scan_idx;
  logic          scan_step;

  assign scan_step = (scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      scan_idx <= 3'd0;
    end else if (scan_step) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == 3'(DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  logic [3:0] cur_nib;
  logic [7:0] cur_seg;
`ifdef BCD_CNT_BLANK_EN
  logic       zero_run;
  logic       cur_blank;

  always_comb begin
    cur_nib   = value[3:0];
    zero_run  = 1'b1;
    cur_blank = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (value[4*i +: 4] == 4'd0);
      if (scan_idx == 3'(i)) begin
        cur_nib   = value[4*i +: 4];
        cur_blank = zero_run && (i != 0);
      end
    end
    cur_seg = cur_blank ? 8'b00000000 : seg_decode(cur_nib);
  end
`else
  always_comb begin
    cur_nib = value[3:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == 3'(i)) cur_nib = value[4*i +: 4];
    end
    cur_seg = seg_decode(cur_nib);
  end
`endif

  // sel and seg come from the same index on the same edge so they never disagree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel <= 3'b111;
      seg <= 8'b00111111;
    end else begin
      sel <= 3'd7 - scan_idx;
      seg <= cur_seg;
    end
  end

endmodule
